// File: rtl/rr_rsp_router.sv
`default_nettype none
// ============================================================================
//  Module   : rr_rsp_router
//  Purpose  : Response router for one slave port. Records, in grant order,
//             which master issued each forwarded request and whether it was
//             a read or a write. Each slave response retires the oldest entry
//             and is steered, one cycle later, to the master that owns it.
//  Revision : 1.0  initial release
// ============================================================================
module rr_rsp_router #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_no,
  input  logic        perm0,
  input  logic        perm1,
  input  logic        cmd_to,
  input  logic        s_resp,
  input  logic [31:0] s_rdata,
  output logic        resp0,
  output logic        resp1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        full,
  output logic        empty,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Tracking storage: one {mid, cmd} pair per outstanding request.
  logic [DEPTH-1:0] mid_q;
  logic [DEPTH-1:0] cmd_q;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic grant_one;
  logic grant_both;
  logic push;
  logic pop;
  logic err_set;
  logic head_mid;
  logic head_cmd;

  // The slave number only identifies this instance when debugging.
  logic unused_s_no;
  assign unused_s_no = s_no;

  assign head_mid = mid_q[rd_ptr];
  assign head_cmd = cmd_q[rd_ptr];

  // Decide push/pop for this cycle and flag every protocol violation.
  // A push while full is still legal if the head retires in the same cycle.
  always_comb begin
    grant_one  = perm0 ^ perm1;
    grant_both = perm0 & perm1;
    pop        = s_resp & ~empty;
    push       = grant_one & (~full | pop);
    err_set    = grant_both
               | (grant_one & full & ~pop)
               | (s_resp & empty);
    count_nxt  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Queue entries carry no reset: they are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mid_q[wr_ptr] <= perm1;
      cmd_q[wr_ptr] <= cmd_to;
    end
  end

  // Pointers, occupancy and the status flags derived from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      if (err_set) err <= 1'b1;
    end
  end

  // Registered response steering; write completions return zero data and
  // the master that is not addressed keeps its last data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0  <= 1'b0;
      resp1  <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      resp0 <= pop & ~head_mid;
      resp1 <= pop & head_mid;
      if (pop && !head_mid) rdata0 <= head_cmd ? 32'd0 : s_rdata;
      if (pop &&  head_mid) rdata1 <= head_cmd ? 32'd0 : s_rdata;
    end
  end

endmodule
`default_nettype wire
